// File: rtl/cplx_addsub_stage.sv
// Complex-multiplier combine stage: two-deep valid/ready pipeline forming re/im from partial products.
// Optional output clamping to the PW-bit signed range is enabled by defining CPLX_SAT_EN.
module cplx_addsub_stage #(
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] p_rr,
  input  logic [PW-1:0] p_ii,
  input  logic [PW-1:0] p_ri,
  input  logic [PW-1:0] p_ir,
  input  logic          conj,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW:0]   re_out,
  output logic [PW:0]   im_out,
  output logic          sat
);

  // Ripple-carry chain of full-adder cells; subtraction passes ~b with cin = 1.
  function automatic logic [PW:0] rippleAdd(input logic [PW:0] a, input logic [PW:0] b,
                                            input logic cin);
    logic [PW:0] s;
    logic        c;
    c = cin;
    for (int k = 0; k <= PW; k++) begin
      s[k] = a[k] ^ b[k] ^ c;
      c    = (a[k] & b[k]) | (c & (a[k] ^ b[k]));
    end
    return s;
  endfunction

  logic          r_s1Valid;
  logic [PW:0]   r_s1Re;
  logic [PW:0]   r_s1Im;
  logic          r_s2Valid;
  logic [PW:0]   r_s2Re;
  logic [PW:0]   r_s2Im;

  logic          w_s1Adv;
  logic          w_s2Adv;
  logic [PW:0]   w_rrExt;
  logic [PW:0]   w_iiExt;
  logic [PW:0]   w_riExt;
  logic [PW:0]   w_irExt;
  logic [PW:0]   w_reSum;
  logic [PW:0]   w_imSum;
  logic [PW:0]   w_reNext;
  logic [PW:0]   w_imNext;

  assign w_s2Adv  = r_s2Valid ? (r_s1Valid & out_ready) : r_s1Valid;
  assign in_ready = ~r_s1Valid | w_s2Adv;
  assign w_s1Adv  = in_valid & in_ready;

  assign w_rrExt = {p_rr[PW-1], p_rr};
  assign w_iiExt = {p_ii[PW-1], p_ii};
  assign w_riExt = {p_ri[PW-1], p_ri};
  assign w_irExt = {p_ir[PW-1], p_ir};

  // conj flips which operand of each pair is subtracted: re = rr -/+ ii, im = ir +/- ri.
  assign w_reSum = rippleAdd(w_rrExt, conj ? w_iiExt : ~w_iiExt, ~conj);
  assign w_imSum = rippleAdd(w_irExt, conj ? ~w_riExt : w_riExt, conj);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1Valid <= 1'b0;
      r_s1Re    <= '0;
      r_s1Im    <= '0;
    end else begin
      r_s1Valid <= w_s1Adv | (r_s1Valid & ~w_s2Adv);
      if (w_s1Adv) begin
        r_s1Re <= w_reSum;
        r_s1Im <= w_imSum;
      end
    end
  end

`ifdef CPLX_SAT_EN
  logic w_reOvf;
  logic w_imOvf;
  logic r_s2Sat;

  // Out of PW-bit range exactly when the two top bits disagree; clamp toward the sign.
  assign w_reOvf  = r_s1Re[PW] ^ r_s1Re[PW-1];
  assign w_imOvf  = r_s1Im[PW] ^ r_s1Im[PW-1];
  assign w_reNext = w_reOvf ? {r_s1Re[PW], r_s1Re[PW], {(PW-1){~r_s1Re[PW]}}} : r_s1Re;
  assign w_imNext = w_imOvf ? {r_s1Im[PW], r_s1Im[PW], {(PW-1){~r_s1Im[PW]}}} : r_s1Im;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2Sat <= 1'b0;
    end else if (w_s2Adv) begin
      r_s2Sat <= w_reOvf | w_imOvf;
    end
  end

  assign sat = r_s2Sat;
`else
  assign w_reNext = r_s1Re;
  assign w_imNext = r_s1Im;
  assign sat      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2Valid <= 1'b0;
      r_s2Re    <= '0;
      r_s2Im    <= '0;
    end else begin
      r_s2Valid <= w_s2Adv | (r_s2Valid & ~out_ready);
      if (w_s2Adv) begin
        r_s2Re <= w_reNext;
        r_s2Im <= w_imNext;
      end
    end
  end

  assign out_valid = r_s2Valid;
  assign re_out    = r_s2Re;
  assign im_out    = r_s2Im;

endmodule

// File: tb/tb_cplx_addsub_stage.sv
// Directed self-checking bench for cplx_addsub_stage (PW = 16); honours CPLX_SAT_EN when defined.
module tb_cplx_addsub_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] p_rr;
  logic [15:0] p_ii;
  logic [15:0] p_ri;
  logic [15:0] p_ir;
  logic        conj;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] re_out;
  logic [16:0] im_out;
  logic        sat;

  int checks = 0;
  int errors = 0;

  cplx_addsub_stage #(.PW(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .p_rr(p_rr), .p_ii(p_ii), .p_ri(p_ri), .p_ir(p_ir), .conj(conj),
    .out_valid(out_valid), .out_ready(out_ready),
    .re_out(re_out), .im_out(im_out), .sat(sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Set k of the streaming tests: rr=10k, ii=k, ri=k, ir=2k, conj=0 -> re=9k, im=3k.
  task automatic driveSetK(input int k);
    p_rr = 16'(10 * k);
    p_ii = 16'(k);
    p_ri = 16'(k);
    p_ir = 16'(2 * k);
    conj = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    driveSetK(3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (re_out !== 17'd0) begin errors++; $display("[TB] FAIL reset_re got %0d want 0", re_out); end
    checks++; if (im_out !== 17'd0) begin errors++; $display("[TB] FAIL reset_im got %0d want 0", im_out); end
    checks++; if (sat !== 1'b0) begin errors++; $display("[TB] FAIL reset_sat got %b want 0", sat); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    int tRr[3] = '{100, 100, 32767};
    int tIi[3] = '{30, 30, -32768};
    int tRi[3] = '{20, 20, -32768};
    int tIr[3] = '{5, 5, -32768};
    logic tCj[3] = '{1'b0, 1'b1, 1'b0};
`ifdef CPLX_SAT_EN
    int tRe[3] = '{70, 130, 32767};
    int tIm[3] = '{25, -15, -32768};
    logic tSat[3] = '{1'b0, 1'b0, 1'b1};
`else
    int tRe[3] = '{70, 130, 65535};
    int tIm[3] = '{25, -15, -65536};
    logic tSat[3] = '{1'b0, 1'b0, 1'b0};
`endif
    logic [16:0] expRe;
    logic [16:0] expIm;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      p_rr = 16'(tRr[i]); p_ii = 16'(tIi[i]); p_ri = 16'(tRi[i]); p_ir = 16'(tIr[i]);
      conj = tCj[i]; in_valid = 1'b1; out_ready = 1'b1;
      expRe = 17'(tRe[i]); expIm = 17'(tIm[i]);
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic%0d_latency got valid %b want 0", i, out_valid); end
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic%0d_valid got %b want 1", i, out_valid); end
      checks++; if (re_out !== expRe) begin errors++; $display("[TB] FAIL basic%0d_re got %0d want %0d", i, $signed(re_out), $signed(expRe)); end
      checks++; if (im_out !== expIm) begin errors++; $display("[TB] FAIL basic%0d_im got %0d want %0d", i, $signed(im_out), $signed(expIm)); end
      checks++; if (sat !== tSat[i]) begin errors++; $display("[TB] FAIL basic%0d_sat got %b want %b", i, sat, tSat[i]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int recv = 0;
    logic acc;
    logic emit;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      out_ready = (c >= 4);
      in_valid  = (sent < 4);
      driveSetK(sent + 1);
      #1;
      acc  = in_valid & in_ready;
      emit = out_valid & out_ready;
      if (c == 2 || c == 3) begin
        checks++; if (sent != 2) begin errors++; $display("[TB] FAIL bp_accepted got %0d want 2", sent); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_c%0d got %b want 0", c, in_ready); end
        checks++; if (out_valid !== 1'b1 || re_out !== 17'd9 || im_out !== 17'd3) begin
          errors++; $display("[TB] FAIL bp_hold_c%0d got v=%b re=%0d im=%0d want v=1 re=9 im=3", c, out_valid, re_out, im_out);
        end
      end
      if (emit) begin
        recv++;
        checks++; if (re_out !== 17'(9 * recv) || im_out !== 17'(3 * recv)) begin
          errors++; $display("[TB] FAIL bp_order%0d got re=%0d im=%0d want re=%0d im=%0d", recv, re_out, im_out, 9 * recv, 3 * recv);
        end
      end
      @(posedge clk);
      if (acc) sent++;
    end
    checks++; if (recv != 4) begin errors++; $display("[TB] FAIL bp_count got %0d want 4", recv); end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [16:0] qRe[$];
    logic [16:0] qIm[$];
    logic [16:0] eRe;
    logic [16:0] eIm;
    int emitted = 0;
    int k;
    logic acc;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      k = 20 + c;
      out_ready = 1'b1;
      in_valid  = (c < 12);
      p_rr = 16'(3 * k); p_ii = 16'(-k); p_ri = 16'(k); p_ir = 16'(-2 * k);
      conj = k[0];
      #1;
      acc = in_valid & in_ready;
      if (c < 12) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_c%0d got %b want 1", c, in_ready); end
      end
      if (c >= 2 && c < 14) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_gap_c%0d got valid %b want 1", c, out_valid); end
      end
      if (out_valid && out_ready) begin
        emitted++;
        if (qRe.size() == 0) begin
          checks++; errors++; $display("[TB] FAIL b2b_extra got unexpected output re=%0d want none", re_out);
        end else begin
          eRe = qRe.pop_front(); eIm = qIm.pop_front();
          checks++; if (re_out !== eRe || im_out !== eIm) begin
            errors++; $display("[TB] FAIL b2b_data got re=%0d im=%0d want re=%0d im=%0d", $signed(re_out), $signed(im_out), $signed(eRe), $signed(eIm));
          end
        end
      end
      if (acc) begin
        qRe.push_back(k[0] ? 17'(2 * k) : 17'(4 * k));
        qIm.push_back(k[0] ? 17'(-3 * k) : 17'(-k));
      end
      @(posedge clk);
    end
    checks++; if (emitted != 12) begin errors++; $display("[TB] FAIL b2b_count got %0d want 12", emitted); end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; driveSetK(5);
    @(negedge clk);
    driveSetK(6);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_valid got %b want 0", out_valid); end
    checks++; if (re_out !== 17'd0 || im_out !== 17'd0) begin errors++; $display("[TB] FAIL mid_rst_data got re=%0d im=%0d want 0 0", re_out, im_out); end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b1; out_ready = 1'b1; driveSetK(7);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_stale got valid %b want 0", out_valid); end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || re_out !== 17'd63 || im_out !== 17'd21) begin
      errors++; $display("[TB] FAIL mid_new got v=%b re=%0d im=%0d want v=1 re=63 im=21", out_valid, re_out, im_out);
    end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_alone got valid %b want 0", out_valid); end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; conj = 1'b0;
    p_rr = '0; p_ii = '0; p_ri = '0; p_ir = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cplx_addsub_stage.md
Name: cplx_addsub_stage

Overview:
- Post-multiplier combine stage of the complex multiplier. Consumes the four signed partial products from the vedic multiplier array and produces the real and imaginary results.
  - real = ar·br − ai·bi
  - imag = ar·bi + ai·br
- Adders and subtractors are built as ripple-carry chains of full-adder cells. Subtraction uses the inverted operand with carry-in = 1.
- Two-stage registered pipeline with a valid/ready handshake on both sides.

Parameters:
- PW, 16, width of each signed two's-complement partial product. Outputs are PW+1 bits wide.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  partial-product set valid
- in_ready  output  1  stage can accept a set this cycle
- p_rr  input  PW  ar·br, signed
- p_ii  input  PW  ai·bi, signed
- p_ri  input  PW  ar·bi, signed
- p_ir  input  PW  ai·br, signed
- conj  input  1  sampled with data; 1 = multiply by conjugate of b
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- re_out  output  PW+1  signed real result
- im_out  output  PW+1  signed imaginary result
- sat  output  1  result was clamped; always 0 unless CPLX_SAT_EN is defined

Behaviour:
- Reset:
  - Reset is sampled only on a rising clk edge with rst_n = 0.
  - Clears both stage valid bits: out_valid = 0, re_out = 0, im_out = 0, sat = 0.
  - in_ready = 1 from the first cycle after reset.
  - Reset mid-operation discards all in-flight sets; no partial output is ever presented.
- Transfers:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
- Stage 1 (S1), on input transfer, registers sign-extended (PW+1) sums:
  - conj = 0: re = p_rr − p_ii, im = p_ri + p_ir
  - conj = 1: re = p_rr + p_ii, im = p_ir − p_ri
  - All PW+1 results are exact; no overflow is possible.
- Stage 2 (S2) is the output register, driving re_out, im_out, sat and out_valid.
- Advance rules:
  - s2_adv = s1_valid & (!s2_valid | out_ready)
  - s1_adv = in_valid & (!s1_valid | s2_adv)
  - in_ready = !s1_valid | s2_adv. This is combinational from out_ready, with no combinational path from in_valid.
- Latency and throughput:
  - Latency is 2 cycles: a set accepted at edge N appears on out_valid after edge N+1.
  - Sustained throughput is 1 set per cycle while out_ready = 1.
- Stall:
  - While out_valid & !out_ready, re_out, im_out and sat hold stable.
  - S1 fills, then in_ready drops.
  - No set is dropped or duplicated; output order equals input order.
- Simultaneous events:
  - Accept and emit in the same cycle are allowed; a full pipe with out_ready = 1 accepts a new set that cycle.
  - in_valid may be deasserted at any time; bubbles propagate as out_valid = 0.
- Inputs are ignored (not registered) when in_valid = 0.

Optional Feature:
- Macro: CPLX_SAT_EN
- Defined: the S2 load step clamps each result to the PW-bit signed range [−2^(PW−1), 2^(PW−1)−1], sign-extended to PW+1.
  - sat = 1 for that output when either component was clamped; otherwise 0.
  - sat holds with the data during a stall.
- Not defined: no clamping; results are the full PW+1 value and sat is tied to 0.

Test Plan:
- Reset: drive rst_n = 0 for 2 cycles with in_valid = 1 → out_valid = 0, re_out = 0, im_out = 0, in_ready = 1 the cycle after release.
- Basic, PW=16: p_rr=100, p_ii=30, p_ri=20, p_ir=5, conj=0, out_ready=1 → 2 cycles later re_out=70, im_out=25. Same operands with conj=1 → re_out=130, im_out=−15.
- Extremes: p_rr=32767, p_ii=−32768, p_ri=−32768, p_ir=−32768, conj=0 →
  - Without macro: re_out=65535, im_out=−65536, sat=0.
  - With CPLX_SAT_EN: re_out=32767, im_out=−32768, sat=1.
- Backpressure: stream sets 1,2,3,4 back-to-back with out_ready=0 for 4 cycles → in_ready falls after 2 sets accepted, out_valid holds set 1 stable, all 4 sets emerge in order once out_ready=1.
- Full-pipe pass-through: pipe full with out_ready=1 and in_valid=1 continuously for 10 cycles → one accept and one emit every cycle, no gaps.
- Reset mid-stream: assert rst_n=0 with 2 sets in flight → out_valid=0 next cycle; the next accepted set emerges alone after 2 cycles.
